// File: rtl/kgp_pkg.sv
// Shared KGP-RISC fetch-stage constants and the next-PC source selector.
package kgp_pkg;

  localparam int          DEF_ADDR_W      = 32;
  localparam int          DEF_INSTR_BYTES = 4;
  localparam logic [31:0] DEF_RESET_VEC   = 32'h0000_0000;

  typedef enum logic [1:0] {
    PC_SEQ   = 2'd0,
    PC_REDIR = 2'd1,
    PC_CALL  = 2'd2,
    PC_RET   = 2'd3
  } pc_sel_e;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack. A push when full overwrites the oldest entry.
// Holds all state while en is low.
module ras_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           top,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty
);

  localparam int               PW   = $clog2(DEPTH);
  localparam int               CW   = PW + 1;
  localparam logic [PW-1:0]    ONE  = PW'(1);
  localparam logic [CW-1:0]    FULL = CW'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] ptr;

  assign top   = mem[ptr];
  assign empty = (count == '0);

  // ptr always names the newest entry; wrapping lets pushes overwrite the oldest.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr   <= '0;
      count <= '0;
    end else if (en) begin
      if (push) begin
        ptr <= ptr + ONE;
        if (count != FULL) count <= count + CW'(1);
      end else if (pop && !empty) begin
        ptr   <= ptr - ONE;
        count <= count - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && en && push) mem[ptr + ONE] <= din;
  end

endmodule

// File: rtl/pc_unit.sv
// Architectural PC with prioritised next-PC selection, alignment checking and a return-address stack.
// pc, ras_count and the underflow/misalign pulses are registered one cycle after the request.
module pc_unit
  import kgp_pkg::*;
#(
  parameter int                ADDR_W      = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_VEC   = ADDR_W'(DEF_RESET_VEC),
  parameter int                INSTR_BYTES = DEF_INSTR_BYTES,
  parameter int                RAS_DEPTH   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       stall,
  input  logic                       redirect,
  input  logic                       call,
  input  logic                       ret,
  input  logic [ADDR_W-1:0]          target,
  output logic [ADDR_W-1:0]          pc,
  output logic [ADDR_W-1:0]          pc_plus,
  output logic [$clog2(RAS_DEPTH):0] ras_count,
  output logic                       ras_empty,
  output logic                       underflow,
  output logic                       misalign
);

  localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'(INSTR_BYTES - 1);
  localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(INSTR_BYTES);

  pc_sel_e           sel;
  logic [ADDR_W-1:0] ras_top;
  logic [ADDR_W-1:0] target_al;
  logic              target_mis;
  logic              push;
  logic              pop;

  // Only the highest-priority request is acted on; the rest are dropped.
  always_comb begin
    sel = PC_SEQ;
    if (redirect)  sel = PC_REDIR;
    else if (call) sel = PC_CALL;
    else if (ret)  sel = PC_RET;
  end

  assign pc_plus    = pc + STEP;
  assign target_al  = target & ~LOW_MASK;
  assign target_mis = |(target & LOW_MASK);
  assign push       = (sel == PC_CALL);
  assign pop        = (sel == PC_RET) && !ras_empty;

  ras_stack #(
    .DEPTH (RAS_DEPTH),
    .W     (ADDR_W)
  ) u_ras (
    .clk   (clk),
    .rst   (rst),
    .en    (!stall),
    .push  (push),
    .pop   (pop),
    .din   (pc_plus),
    .top   (ras_top),
    .count (ras_count),
    .empty (ras_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= RESET_VEC;
      underflow <= 1'b0;
      misalign  <= 1'b0;
    end else begin
      underflow <= 1'b0;
      misalign  <= 1'b0;
      if (!stall) begin
        case (sel)
          PC_REDIR, PC_CALL: begin
            pc       <= target_al;
            misalign <= target_mis;
          end
          PC_RET: begin
            if (ras_empty) begin
              pc        <= pc_plus;
              underflow <= 1'b1;
            end else begin
              pc <= ras_top;
            end
          end
          default: pc <= pc_plus;
        endcase
      end
    end
  end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the KGP-RISC fetch stage. It holds the architectural PC and computes the next PC from sequential increment, branch/jump redirect, call and return. Return addresses come from an internal circular return-address stack (RAS). It replaces the bare PC register, sits between the branch/control logic and the instruction memory address port, and adds stall, alignment checking and call/return tracking.

## Interface
- ADDR_W, 32: PC width in bits.
- RESET_VEC, 0: PC value after reset (ADDR_W bits, aligned).
- INSTR_BYTES, 4: PC increment per instruction; power of two.
- RAS_DEPTH, 4: return-address stack entries; power of two, ≥2.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hold PC, RAS and flags unchanged this cycle.
- redirect  in  1  load PC from target (branch/jump).
- call  in  1  push PC+INSTR_BYTES, load PC from target.
- ret  in  1  pop RAS into PC.
- target  in  ADDR_W  destination for redirect/call.
- pc  out  ADDR_W  current PC (registered).
- pc_plus  out  ADDR_W  pc+INSTR_BYTES (combinational).
- ras_count  out  $clog2(RAS_DEPTH)+1  valid RAS entries (registered).
- ras_empty  out  1  ras_count==0.
- underflow  out  1  one-cycle pulse, registered: ret taken with empty RAS.
- misalign  out  1  one-cycle pulse, registered: redirect/call target not aligned.

## Operation
- Priority per cycle: rst > stall > redirect > call > ret > sequential.
- Sequential: pc ← pc+INSTR_BYTES.
- Redirect: pc ← target with the low log2(INSTR_BYTES) bits forced to 0. misalign pulses if any of those bits were 1. RAS unchanged.
- Call: push pc+INSTR_BYTES; pc ← aligned target; misalign rule as for redirect.
- Ret, RAS non-empty: pc ← top entry; pop; ras_count−1.
- Ret, RAS empty: pc ← pc+INSTR_BYTES; underflow pulses.
- RAS push when full: overwrite oldest entry (circular top pointer advances); ras_count stays RAS_DEPTH; no error flag.
- All PC arithmetic is modulo 2^ADDR_W. Increment from the all-ones aligned address wraps to 0.
- Stall: every register holds, including pc, RAS pointer, entries and count. underflow and misalign deassert.
- Lower-priority requests in the same cycle are ignored, not queued. Example: redirect+ret pops nothing.
- Reset values: pc=RESET_VEC, ras_count=0, ras_empty=1, underflow=0, misalign=0. RAS entry contents are don't-care.

## Timing
- pc updates one cycle after the request is sampled. pc_plus follows pc in the same cycle.
- underflow and misalign assert in the cycle pc shows the result of the causing request, for exactly one cycle.
- Reset asserted mid-sequence (e.g. during a call) discards the request and takes effect at that edge.
- Back-to-back call/ret on consecutive cycles is supported with no bubble. Ret in cycle n+1 returns the address pushed in cycle n.

## Structure
- Shared package kgp_pkg:
  - default ADDR_W, INSTR_BYTES and RESET_VEC constants.
  - pc_sel_e enum {PC_SEQ, PC_REDIR, PC_CALL, PC_RET}, used by the priority decoder and bench coverage.
- Sub-module ras_stack (parameters DEPTH, W):
  - circular buffer with push, pop, top, count and empty.
  - overwrite-on-full behaviour.
  - enable input driven by !stall.
- pc_unit holds the priority decode, alignment logic, pc register and pulse flags.

## Test plan
- Reset then 3 free-running cycles, defaults → pc = 0, 4, 8, 12; ras_empty=1.
- redirect with target=0x103 → next pc=0x100, misalign=1 for one cycle; then pc=0x104.
- call with target=0x200 at pc=0x40, then ret next cycle → pc=0x200, then 0x44; ras_count 1 then 0.
- 5 nested calls, RAS_DEPTH=4, then 5 rets → first 4 rets return the 4 newest link addresses. 5th ret gives underflow=1 and pc=prev+4.
- stall high 3 cycles with redirect asserted → pc, ras_count unchanged. Redirect is honoured on the first unstalled cycle.
- pc=0xFFFFFFFC sequential → pc=0x00000000. rst asserted alongside call → pc=RESET_VEC, ras_count=0.
